alt_eyemon_mc: RTL and testbench

Parametrised multi-channel successor to the single-register-set eye monitor (EyeQ) simulation model. It exposes a 4-register Avalon-MM slave (control/status, channel, word, data) over a per-channel, per-word storage array. The array emulates transceiver DPRIO eye-monitor settings, with configurable operation latencies, sticky done/error flags and word-address auto-increment. It sits between the reconfig Avalon master and the per-channel eye-monitor enables in ASE simulation.

---
 rtl/alt_eyemon_mc_if.sv | 20 ++
 rtl/alt_eyemon_mc.sv | 210 +++++++++++++++++++++
 tb/tb_alt_eyemon_mc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alt_eyemon_mc_if.sv
// Avalon-MM slave bus bundle for the multi-channel eye-monitor register block.
interface alt_eyemon_mc_if #(
  parameter int avmm_slave_addr_width = 2
);
  logic [avmm_slave_addr_width-1:0] i_avmm_saddress;
  logic                             i_avmm_sread;
  logic                             i_avmm_swrite;
  logic [15:0]                      i_avmm_swritedata;
  logic [15:0]                      o_avmm_sreaddata;
  logic                             o_avmm_swaitrequest;

  modport master (
    output i_avmm_saddress, i_avmm_sread, i_avmm_swrite, i_avmm_swritedata,
    input  o_avmm_sreaddata, o_avmm_swaitrequest
  );
  modport slave (
    input  i_avmm_saddress, i_avmm_sread, i_avmm_swrite, i_avmm_swritedata,
    output o_avmm_sreaddata, o_avmm_swaitrequest
  );
endinterface

// File: rtl/alt_eyemon_mc.sv
// Multi-channel eye-monitor DPRIO emulation: 4-register Avalon slave over a
// per-channel/per-word storage array with timed read/write operations.
module alt_eyemon_mc #(
  parameter int num_channels          = 12,
  parameter int channel_address_width = 4,
  parameter int num_words             = 4,
  parameter int word_address_width    = 2,
  parameter int word_width            = 8,
  parameter int avmm_slave_addr_width = 2,
  parameter int write_latency         = 64,
  parameter int read_latency          = 32
) (
  input  logic                    i_avmm_clk,
  input  logic                    i_reset,
  alt_eyemon_mc_if.slave          avmm,
  output logic                    o_reconfig_busy,
  output logic                    o_done_pulse,
  output logic [num_channels-1:0] o_ch_enable
);
  localparam int MAX_LAT = (write_latency > read_latency) ? write_latency : read_latency;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int CAW     = channel_address_width;
  localparam int WAW     = word_address_width;

  typedef enum logic {IDLE, ACK} bus_state_e;

  bus_state_e state_q, state_d;
  logic [15:0] rdata_q, rdata_d;
  logic start_q, start_d, op_q, op_d, ainc_q, ainc_d;
  logic err_q, err_d, done_q, done_d, inv_ch_q, inv_ch_d, inv_wd_q, inv_wd_d;
  logic busy_q, busy_d, pulse_q, pulse_d;
  logic [CAW-1:0] chan_q, chan_d, snap_ch_q, snap_ch_d;
  logic [WAW-1:0] word_q, word_d, snap_wd_q, snap_wd_d;
  logic [15:0] data_q, data_d;
  logic [word_width-1:0] snap_data_q, snap_data_d;
  logic snap_op_q, snap_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [word_width-1:0] mem_q [num_channels][num_words];
  logic [word_width-1:0] mem_d [num_channels][num_words];

  logic [31:0] addr;
  logic [15:0] wdata;
  logic host_rd, host_wr, ch_ok, wd_ok;

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    start_d     = start_q;
    op_d        = op_q;
    ainc_d      = ainc_q;
    err_d       = err_q;
    done_d      = done_q;
    inv_ch_d    = inv_ch_q;
    inv_wd_d    = inv_wd_q;
    busy_d      = busy_q;
    pulse_d     = 1'b0;
    chan_d      = chan_q;
    word_d      = word_q;
    data_d      = data_q;
    snap_ch_d   = snap_ch_q;
    snap_wd_d   = snap_wd_q;
    snap_data_d = snap_data_q;
    snap_op_d   = snap_op_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    avmm.o_avmm_swaitrequest = 1'b0;

    addr    = 32'(avmm.i_avmm_saddress);
    wdata   = avmm.i_avmm_swritedata;
    host_rd = (state_q == IDLE) && avmm.i_avmm_sread;
    host_wr = (state_q == IDLE) && avmm.i_avmm_swrite && !avmm.i_avmm_sread;
    ch_ok   = 32'(chan_q) < num_channels;
    wd_ok   = 32'(word_q) < num_words;

    case (state_q)
      IDLE: if (avmm.i_avmm_sread || avmm.i_avmm_swrite) begin
        avmm.o_avmm_swaitrequest = 1'b1;
        state_d = ACK;
      end
      default: state_d = IDLE;
    endcase

    if (host_rd) begin
      case (addr)
        32'd0:   rdata_d = {busy_q, inv_wd_q, inv_ch_q, done_q, err_q, 8'h00, ainc_q, op_q, start_q};
        32'd1:   rdata_d = 16'(chan_q);
        32'd2:   rdata_d = 16'(word_q);
        32'd3:   rdata_d = data_q;
        default: rdata_d = '0;
      endcase
    end

    if (host_wr) begin
      if (busy_q) begin
        // Only a pure W1C status write is accepted mid-operation.
        if (addr == 32'd0 && !wdata[0]) begin
          err_d    = err_q    & ~wdata[11];
          done_d   = done_q   & ~wdata[12];
          inv_ch_d = inv_ch_q & ~wdata[13];
          inv_wd_d = inv_wd_q & ~wdata[14];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (addr)
          32'd0: begin
            op_d     = wdata[1];
            ainc_d   = wdata[2];
            err_d    = err_q    & ~wdata[11];
            done_d   = done_q   & ~wdata[12];
            inv_ch_d = inv_ch_q & ~wdata[13];
            inv_wd_d = inv_wd_q & ~wdata[14];
            if (wdata[0]) begin
              if (ch_ok && wd_ok) begin
                start_d     = 1'b1;
                busy_d      = 1'b1;
                inv_ch_d    = 1'b0;
                inv_wd_d    = 1'b0;
                snap_ch_d   = chan_q;
                snap_wd_d   = word_q;
                snap_data_d = data_q[word_width-1:0];
                snap_op_d   = wdata[1];
                cnt_d       = wdata[1] ? CNT_W'(read_latency) : CNT_W'(write_latency);
              end else begin
                if (!ch_ok) inv_ch_d = 1'b1;
                if (!wd_ok) inv_wd_d = 1'b1;
              end
            end
          end
          32'd1:   chan_d = wdata[CAW-1:0];
          32'd2:   word_d = wdata[WAW-1:0];
          32'd3:   data_d = wdata;
          default: ;
        endcase
      end
    end

    // Completion is evaluated after host W1C so a same-edge done set wins.
    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d  = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b1;
        pulse_d = 1'b1;
        cnt_d   = '0;
        if (snap_op_q) data_d = 16'(mem_q[snap_ch_q][snap_wd_q]);
        else           mem_d[snap_ch_q][snap_wd_q] = snap_data_q;
        if (ainc_q)
          word_d = (32'(snap_wd_q) == num_words - 1) ? '0 : snap_wd_q + WAW'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_avmm_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      start_q     <= 1'b0;
      op_q        <= 1'b0;
      ainc_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      inv_ch_q    <= 1'b0;
      inv_wd_q    <= 1'b0;
      busy_q      <= 1'b0;
      pulse_q     <= 1'b0;
      chan_q      <= '0;
      word_q      <= '0;
      data_q      <= '0;
      snap_ch_q   <= '0;
      snap_wd_q   <= '0;
      snap_data_q <= '0;
      snap_op_q   <= 1'b0;
      cnt_q       <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      start_q     <= start_d;
      op_q        <= op_d;
      ainc_q      <= ainc_d;
      err_q       <= err_d;
      done_q      <= done_d;
      inv_ch_q    <= inv_ch_d;
      inv_wd_q    <= inv_wd_d;
      busy_q      <= busy_d;
      pulse_q     <= pulse_d;
      chan_q      <= chan_d;
      word_q      <= word_d;
      data_q      <= data_d;
      snap_ch_q   <= snap_ch_d;
      snap_wd_q   <= snap_wd_d;
      snap_data_q <= snap_data_d;
      snap_op_q   <= snap_op_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

  always_comb begin
    o_ch_enable = '0;
    for (int unsigned c = 0; c < num_channels; c++) o_ch_enable[c] = mem_q[c][0][0];
  end

  assign avmm.o_avmm_sreaddata = rdata_q;
  assign o_reconfig_busy       = busy_q;
  assign o_done_pulse          = pulse_q;
endmodule

// File: tb/tb_alt_eyemon_mc.sv
// Directed self-checking bench for alt_eyemon_mc with default parameters.
module tb_alt_eyemon_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, pulse;
  logic [11:0] ch_en;
  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles  = 0;
  int pulse_cycles = 0;
  logic [15:0] rd;

  alt_eyemon_mc_if #(.avmm_slave_addr_width(2)) bus ();

  alt_eyemon_mc #(
    .num_channels(12), .channel_address_width(4), .num_words(4),
    .word_address_width(2), .word_width(8), .avmm_slave_addr_width(2),
    .write_latency(64), .read_latency(32)
  ) dut (
    .i_avmm_clk(clk), .i_reset(rst), .avmm(bus),
    .o_reconfig_busy(busy), .o_done_pulse(pulse), .o_ch_enable(ch_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy)  busy_cycles++;
    if (pulse) pulse_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.i_avmm_saddress = a; bus.i_avmm_swritedata = d; bus.i_avmm_swrite = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.i_avmm_swrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.i_avmm_saddress = a; bus.i_avmm_sread = 1'b1;
    @(negedge clk);
    d = bus.o_avmm_sreaddata;
    @(negedge clk);
    bus.i_avmm_sread = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    bus.i_avmm_saddress = '0; bus.i_avmm_sread = 1'b0;
    bus.i_avmm_swrite = 1'b0; bus.i_avmm_swritedata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chen", 32'(ch_en), 32'd0);
    check("rst_rdata", 32'(bus.o_avmm_sreaddata), 32'd0);
    rst = 1'b0;
    bus_rd(2'd0, rd); check("rst_ctrl", 32'(rd), 32'h0000);

    // Write op: storage[3][0] = 1
    bus_wr(2'd1, 16'd3); bus_wr(2'd2, 16'd0); bus_wr(2'd3, 16'd1);
    busy_cycles = 0; pulse_cycles = 0;
    bus_wr(2'd0, 16'h0001);
    wait_idle(200);
    repeat (3) @(negedge clk);
    check("wr_busy_len", 32'(busy_cycles), 32'd64);
    check("wr_pulse_len", 32'(pulse_cycles), 32'd1);
    check("wr_chen", 32'(ch_en), 32'h008);
    bus_rd(2'd0, rd); check("wr_ctrl_done", 32'(rd), 32'h1000);

    // storage[3][1] = 0x5A, then read it back into a cleared DATA
    bus_wr(2'd2, 16'd1); bus_wr(2'd3, 16'h005A); bus_wr(2'd0, 16'h0001); wait_idle(200);
    bus_wr(2'd3, 16'h0000);
    busy_cycles = 0;
    bus_wr(2'd0, 16'h0003); wait_idle(200);
    check("rd_busy_len", 32'(busy_cycles), 32'd32);
    bus_rd(2'd3, rd); check("rd_data", 32'(rd), 32'h005A);

    // Read with auto-increment from the last word wraps WORD to 0
    bus_wr(2'd2, 16'd3); bus_wr(2'd0, 16'h0007); wait_idle(200);
    bus_rd(2'd2, rd); check("ainc_wrap", 32'(rd), 32'd0);
    bus_rd(2'd3, rd); check("ainc_data", 32'(rd), 32'h0000);
    bus_rd(2'd0, rd); check("ainc_ctrl", 32'(rd), 32'h1006);

    // Invalid channel
    bus_wr(2'd0, 16'h1000);
    bus_wr(2'd1, 16'd12);
    busy_cycles = 0;
    bus_wr(2'd0, 16'h0001);
    repeat (5) @(negedge clk);
    check("inv_no_busy", 32'(busy_cycles), 32'd0);
    bus_rd(2'd0, rd); check("inv_ctrl", 32'(rd), 32'h2000);
    bus_wr(2'd0, 16'h2000);
    bus_rd(2'd0, rd); check("inv_w1c", 32'(rd), 32'h0000);
    bus_wr(2'd1, 16'h0013);
    bus_rd(2'd1, rd); check("chan_trunc", 32'(rd), 32'h0003);

    // Writes while busy
    bus_wr(2'd2, 16'd2); bus_wr(2'd3, 16'h0033);
    busy_cycles = 0;
    bus_wr(2'd0, 16'h0001);
    bus_wr(2'd3, 16'hFFFF);
    bus_rd(2'd3, rd); check("busy_drop_data", 32'(rd), 32'h0033);
    bus_rd(2'd0, rd); check("busy_err_set", 32'(rd), 32'h8801);
    bus_wr(2'd0, 16'h0800);
    bus_rd(2'd0, rd); check("busy_err_w1c", 32'(rd), 32'h8001);
    wait_idle(200);
    check("busy_op_len", 32'(busy_cycles), 32'd64);
    bus_rd(2'd0, rd); check("busy_done", 32'(rd), 32'h1000);
    bus_wr(2'd3, 16'h0000); bus_wr(2'd0, 16'h1003); wait_idle(200);
    bus_rd(2'd3, rd); check("busy_stored", 32'(rd), 32'h0033);

    // Reset in the middle of a write op to storage[5][0]
    bus_wr(2'd1, 16'd5); bus_wr(2'd2, 16'd0); bus_wr(2'd3, 16'h0001);
    bus_wr(2'd0, 16'h1001);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pulse", 32'(pulse), 32'd0);
    check("mid_rst_chen", 32'(ch_en), 32'd0);
    check("mid_rst_rdata", 32'(bus.o_avmm_sreaddata), 32'd0);
    check("mid_rst_wait", 32'(bus.o_avmm_swaitrequest), 32'd0);
    @(negedge clk); rst = 1'b0;
    bus_wr(2'd1, 16'd5); bus_wr(2'd2, 16'd0); bus_wr(2'd3, 16'h0077);
    bus_wr(2'd0, 16'h0003); wait_idle(200);
    bus_rd(2'd3, rd); check("mid_rst_word", 32'(rd), 32'h0000);

    // Simultaneous read and write: read wins
    bus_wr(2'd3, 16'h1234);
    @(negedge clk);
    bus.i_avmm_saddress = 2'd3; bus.i_avmm_swritedata = 16'hBEEF;
    bus.i_avmm_sread = 1'b1; bus.i_avmm_swrite = 1'b1;
    #1 check("rw_wait_hi", 32'(bus.o_avmm_swaitrequest), 32'd1);
    @(negedge clk);
    check("rw_wait_lo", 32'(bus.o_avmm_swaitrequest), 32'd0);
    check("rw_rdata", 32'(bus.o_avmm_sreaddata), 32'h1234);
    @(negedge clk);
    bus.i_avmm_sread = 1'b0; bus.i_avmm_swrite = 1'b0;
    bus_rd(2'd3, rd); check("rw_data_kept", 32'(rd), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
